// File: rtl/and_barrier_collector.sv
`default_nettype none
// ============================================================================
// Module   : and_barrier_collector
// Brief    : Collects per-lane arrival pulses into a sticky vector for the AND
//            reducer; reports completion or timeout through valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module and_barrier_collector #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lane_en,
    input  logic [WIDTH-1:0] arrive,
    output logic [WIDTH-1:0] collected,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sticky;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_count;
    logic             r_timed_out;

    logic [WIDTH-1:0] w_next_sticky;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_all;
    logic             w_expire;

    assign w_next_sticky = r_sticky | (arrive & r_mask);
    assign w_all         = &(w_next_sticky | ~r_mask);
    assign w_count_inc   = r_count + c_one;
    assign w_expire      = (w_count_inc == c_timeout);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_COLLECT;
            ST_COLLECT: if (w_all || w_expire) w_state_next = ST_DONE;
            ST_DONE:    if (done_ready) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers; everything is frozen in DONE so the result holds
    // stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky    <= '0;
            r_mask      <= '0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask      <= lane_en;
                        r_sticky    <= arrive & lane_en;
                        r_count     <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    r_sticky <= w_next_sticky;
                    r_count  <= w_count_inc;
                    // Completion has priority over a simultaneous timeout.
                    if (!w_all && w_expire) begin
                        r_timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign collected  = (r_state == ST_IDLE) ? '0 : (r_sticky | ~r_mask);
    assign busy       = (r_state == ST_COLLECT);
    assign done_valid = (r_state == ST_DONE);
    assign timed_out  = r_timed_out;
    assign cycles     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_and_barrier_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_barrier_collector
// Brief    : Scoreboard bench: stimulus queues expected results, monitor checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_and_barrier_collector;

    localparam int W   = 8;
    localparam int TMO = 10;
    localparam int CW  = $clog2(TMO + 1);

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          start      = 1'b0;
    logic          done_ready = 1'b1;
    logic [W-1:0]  lane_en    = '0;
    logic [W-1:0]  arrive     = '0;
    logic [W-1:0]  collected;
    logic          busy;
    logic          done_valid;
    logic          timed_out;
    logic [CW-1:0] cycles;

    typedef struct {
        logic [W-1:0]  col;
        logic          tmo;
        logic [CW-1:0] cyc;
        int unsigned   at;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    bit          seen  = 1'b0;

    and_barrier_collector #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .lane_en    (lane_en),
        .arrive     (arrive),
        .collected  (collected),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .timed_out  (timed_out),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] col, input logic tmo,
                        input logic [CW-1:0] cy, input int unsigned at);
        exp_t e;
        e.col = col; e.tmo = tmo; e.cyc = cy; e.at = at;
        sb.push_back(e);
    endtask

    // Monitor: first cycle of each done_valid pulse is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (done_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_collected", collected, e.col);
                check("done_timed_out", timed_out, e.tmo);
                check("done_cycles", cycles, e.cyc);
                check("done_latency", cyc, e.at);
            end
        end
        if (!done_valid) seen = 1'b0;
    end

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_idle_valid"}, done_valid, 1'b0);
        check({name, "_idle_collected"}, collected, '0);
    endtask

    task automatic run_all_arrive();
        @(negedge clk); start = 1'b1; lane_en = 8'hFF; arrive = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); start = 1'b0; arrive = W'(1) << i;
            if (i == 3) check("t1_busy", busy, 1'b1);
            if (i == 7) push(8'hFF, 1'b0, CW'(8), cyc + 1);
        end
        @(negedge clk); arrive = '0;
        idle_check("t1");
    endtask

    initial begin
        #100000;
        check("watchdog", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #12;
        check("rst_collected", collected, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", done_valid, 1'b0);
        check("rst_timed_out", timed_out, 1'b0);
        check("rst_cycles", cycles, '0);
        @(negedge clk); reset_n = 1'b1;

        // T1: lanes arrive one per cycle
        run_all_arrive();

        // T2: partial mask, start-cycle capture and a re-pulse
        @(negedge clk); start = 1'b1; lane_en = 8'h0F; arrive = 8'h01;
        @(negedge clk); start = 1'b0; arrive = 8'h01;
        @(negedge clk); arrive = 8'h02;
        check("t2_collected_mid", collected, 8'hF1);
        @(negedge clk); arrive = 8'h04;
        @(negedge clk); arrive = 8'h08; push(8'hFF, 1'b0, CW'(4), cyc + 1);
        @(negedge clk); arrive = '0;
        idle_check("t2");

        // No lanes enabled: completes after one COLLECT cycle
        @(negedge clk); start = 1'b1; lane_en = '0; arrive = 8'hFF;
        push(8'hFF, 1'b0, CW'(1), cyc + 2);
        @(negedge clk); start = 1'b0; arrive = '0;
        @(negedge clk);
        idle_check("t0");

        // T3: lane 3 never arrives
        @(negedge clk); start = 1'b1; lane_en = 8'hFF; arrive = '0;
        push(8'hF7, 1'b1, CW'(10), cyc + 11);
        @(negedge clk); start = 1'b0; arrive = 8'hF7;
        @(negedge clk); arrive = '0;
        repeat (8) @(negedge clk);
        check("t3_busy_before_expire", busy, 1'b1);
        @(negedge clk);
        idle_check("t3");

        // T4: last lane arrives on the timeout cycle
        @(negedge clk); start = 1'b1; lane_en = 8'hFF; arrive = '0;
        @(negedge clk); start = 1'b0; arrive = 8'h7F;
        @(negedge clk); arrive = '0;
        repeat (7) @(negedge clk);
        @(negedge clk); arrive = 8'h80; push(8'hFF, 1'b0, CW'(10), cyc + 1);
        @(negedge clk); arrive = '0;
        idle_check("t4");

        // T5: backpressure with noisy inputs while holding the result
        done_ready = 1'b0;
        @(negedge clk); start = 1'b1; lane_en = 8'h03; arrive = 8'h03;
        push(8'hFF, 1'b0, CW'(1), cyc + 2);
        @(negedge clk); start = 1'b0; arrive = '0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = k[0]; arrive = 8'h5A ^ W'(k); lane_en = 8'hC0;
            check("t5_hold_valid", done_valid, 1'b1);
            check("t5_hold_collected", collected, 8'hFF);
            check("t5_hold_cycles", cycles, CW'(1));
            check("t5_hold_timed_out", timed_out, 1'b0);
        end
        @(negedge clk); done_ready = 1'b1; start = 1'b1; lane_en = 8'h01; arrive = '0;
        @(negedge clk);
        check("t5_start_ignored_busy", busy, 1'b0);
        check("t5_released_valid", done_valid, 1'b0);
        arrive = 8'h01; push(8'hFF, 1'b0, CW'(1), cyc + 2);
        @(negedge clk); start = 1'b0; arrive = '0;
        @(negedge clk);
        idle_check("t5");

        // T6: asynchronous reset in the middle of COLLECT
        @(negedge clk); start = 1'b1; lane_en = 8'hFF; arrive = '0;
        @(negedge clk); start = 1'b0; arrive = 8'h0F;
        @(negedge clk); arrive = '0;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("t6_collected", collected, '0);
        check("t6_busy", busy, 1'b0);
        check("t6_valid", done_valid, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        run_all_arrive();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
